// File: rtl/demux_stream_n.sv
// Registered 1-to-N stream demultiplexer with a one-entry holding register per channel.
// Routes each beat by in_sel (mode 0) or by an internal round-robin pointer (mode 1).
module demux_stream_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]          rr_ptr,
    output logic                      drop_err,
    output logic [7:0]                drop_cnt
);

    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [SEL_W-1:0] rr_advance(input logic [SEL_W-1:0] p);
        return (p == LAST_CH) ? '0 : p + 1'b1;
    endfunction

    logic [CHANNELS-1:0] valid_p0;
    logic [WIDTH-1:0]    data_p0 [CHANNELS];
    logic [SEL_W-1:0]    rr_p0;

    logic [SEL_W-1:0]    tgt;
    logic                in_range;
    logic                chan_ready;
    logic                accept;
    logic                fire_drop;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] load;

    // Routing decision: out-of-range selects are always accepted so they can be discarded.
    always_comb begin
        tgt      = mode ? rr_p0 : in_sel;
        in_range = mode | ({1'b0, in_sel} < CH_LIMIT);
        for (int k = 0; k < CHANNELS; k++) begin
            hit[k] = in_range && (tgt == SEL_W'(k));
        end
        chan_ready = |(hit & (~valid_p0 | out_ready));
        in_ready   = in_range ? chan_ready : 1'b1;
        accept     = in_valid & in_ready;
        load       = hit & {CHANNELS{accept}};
        fire_drop  = accept & ~in_range;
    end

    // Stage p0: per-channel holding registers, round-robin pointer and drop statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_p0 <= '0;
            rr_p0    <= '0;
            drop_err <= 1'b0;
            drop_cnt <= 8'd0;
            for (int k = 0; k < CHANNELS; k++) begin
                data_p0[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (load[k]) begin
                    valid_p0[k] <= 1'b1;
                    data_p0[k]  <= in_data;
                end else if (out_ready[k]) begin
                    valid_p0[k] <= 1'b0;
                end
            end
            if (accept && mode) begin
                rr_p0 <= rr_advance(rr_p0);
            end
            drop_err <= fire_drop;
            if (fire_drop) begin
                drop_cnt <= sat_inc8(drop_cnt);
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
            assign out_data[g*WIDTH +: WIDTH] = data_p0[g];
        end
    endgenerate

    assign out_valid = valid_p0;
    assign rr_ptr    = rr_p0;

endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n: a 4-channel and a 3-channel instance, driven one at a time,
// each compared every cycle against an array-based model of the channel registers.
module tb_demux_stream_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_ready;
    int          cur = 4;

    always #5 clk = ~clk;

    logic        iv4, iv3;
    logic        ir4, ir3;
    logic [3:0]  ov4;
    logic [2:0]  ov3;
    logic [31:0] od4;
    logic [23:0] od3;
    logic [1:0]  rr4, rr3;
    logic        de4, de3;
    logic [7:0]  dc4, dc3;

    assign iv4 = in_valid && (cur == 4);
    assign iv3 = in_valid && (cur == 3);

    demux_stream_n #(.WIDTH(8), .CHANNELS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(iv4), .in_ready(ir4),
        .in_data(in_data), .in_sel(in_sel), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .rr_ptr(rr4), .drop_err(de4), .drop_cnt(dc4)
    );

    demux_stream_n #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(iv3), .in_ready(ir3),
        .in_data(in_data), .in_sel(in_sel), .out_valid(ov3), .out_ready(out_ready[2:0]),
        .out_data(od3), .rr_ptr(rr3), .drop_err(de3), .drop_cnt(dc3)
    );

    logic        o_ready, o_derr;
    logic [3:0]  o_valid;
    logic [31:0] o_data;
    logic [1:0]  o_rr;
    logic [7:0]  o_dcnt;

    always_comb begin
        o_ready = (cur == 4) ? ir4 : ir3;
        o_valid = (cur == 4) ? ov4 : {1'b0, ov3};
        o_data  = (cur == 4) ? od4 : {8'h00, od3};
        o_rr    = (cur == 4) ? rr4 : rr3;
        o_derr  = (cur == 4) ? de4 : de3;
        o_dcnt  = (cur == 4) ? dc4 : dc3;
    end

    // Reference model: one full flag and payload per channel, pointer, drop stats.
    bit          full [4];
    logic [7:0]  mdata [4];
    int          rr, dcnt;
    bit          derr;
    bit          last_acc;
    int          n_chk = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            full[k]  = 1'b0;
            mdata[k] = 8'h00;
        end
        rr = 0; dcnt = 0; derr = 1'b0; last_acc = 1'b0;
    endtask

    function automatic bit exp_ready();
        int t;
        if (!mode && int'(in_sel) >= cur) return 1'b1;
        t = mode ? rr : int'(in_sel);
        return !full[t] || out_ready[t];
    endfunction

    task automatic model_edge();
        bit rdy, inr;
        int t;
        rdy = exp_ready();
        inr = mode || (int'(in_sel) < cur);
        t   = mode ? rr : int'(in_sel);
        for (int k = 0; k < cur; k++) begin
            if (full[k] && out_ready[k]) full[k] = 1'b0;
        end
        derr     = 1'b0;
        last_acc = in_valid && rdy;
        if (last_acc) begin
            if (inr) begin
                full[t]  = 1'b1;
                mdata[t] = in_data;
                if (mode) rr = (rr + 1) % cur;
            end else begin
                derr = 1'b1;
                if (dcnt < 255) dcnt++;
            end
        end
    endtask

    task automatic check_state();
        logic [3:0]  ev;
        logic [31:0] ed;
        ev = '0;
        ed = '0;
        for (int k = 0; k < cur; k++) begin
            ev[k]         = full[k];
            ed[k*8 +: 8]  = mdata[k];
        end
        chk("out_valid", o_valid, ev);
        chk("out_data", o_data, ed);
        chk("rr_ptr", o_rr, rr);
        chk("drop_err", o_derr, derr);
        chk("drop_cnt", o_dcnt, dcnt);
    endtask

    // Starts and ends on a falling edge; inputs are set by the caller beforehand.
    task automatic cycle();
        #1 chk("in_ready", o_ready, exp_ready());
        @(posedge clk);
        model_edge();
        #1 check_state();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic m);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_sel = s; mode = m;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
                in_sel   = 2'($urandom_range(0, 3));
                mode     = 1'($urandom_range(0, 1));
            end
            out_ready = 4'($urandom);
            cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_sel = 2'd0; out_ready = 4'h0;
        model_reset();
        #2;
        check_state();
        chk("reset_in_ready", o_ready, 1'b1);
        do_reset();

        // Addressed routing
        send(8'hA1, 2'd0, 1'b0);
        chk("addr_valid0", o_valid, 4'b0001);
        send(8'hB2, 2'd3, 1'b0);
        chk("addr_valid", o_valid, 4'b1001);
        chk("addr_ch0", o_data[7:0], 8'hA1);
        chk("addr_ch3", o_data[31:24], 8'hB2);

        // Backpressure on channel 1
        send(8'hC3, 2'd1, 1'b0);
        in_valid = 1'b1; in_data = 8'hD4; in_sel = 2'd1;
        #1 chk("bp_in_ready", o_ready, 1'b0);
        cycle();
        chk("bp_hold", o_data[15:8], 8'hC3);
        out_ready = 4'b0010;
        cycle();
        in_valid = 1'b0;
        chk("bp_valid1", o_valid[1], 1'b1);
        chk("bp_new", o_data[15:8], 8'hD4);

        // Round-robin over all channels with free consumers
        out_ready = 4'hF;
        cycle();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h10 + i); mode = 1'b1;
            cycle();
            chk("rr_valid", o_valid[i % 4], 1'b1);
            chk("rr_data", o_data[(i % 4)*8 +: 8], 8'(8'h10 + i));
        end
        in_valid = 1'b0;
        chk("rr_end", o_rr, 2'd2);
        mode = 1'b0;
        cycle();
        chk("rr_keep", o_rr, 2'd2);

        // Asynchronous reset mid-traffic with channel 2 full
        out_ready = 4'h0;
        send(8'h55, 2'd2, 1'b0);
        chk("pre_rst_ch2", o_valid[2], 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_state();
        chk("rst_in_ready", o_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous drain and fill on channel 0
        out_ready = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h60 + i); in_sel = 2'd0; mode = 1'b0;
            #1 chk("ff_no_stall", o_ready, 1'b1);
            cycle();
            chk("ff_valid", o_valid[0], 1'b1);
            chk("ff_data", o_data[7:0], 8'(8'h60 + i));
        end
        in_valid = 1'b0;
        out_ready = 4'h0;

        rand_phase(400);

        // Three-channel instance: out-of-range selects
        cur = 3;
        do_reset();
        in_valid = 1'b1; in_sel = 2'd3; mode = 1'b0; in_data = 8'h77;
        #1 chk("oor_ready", o_ready, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("oor_err", o_derr, 1'b1);
        chk("oor_cnt", o_dcnt, 8'd1);
        chk("oor_valid", o_valid, 4'b0000);
        cycle();
        chk("oor_pulse", o_derr, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) cycle();
        in_valid = 1'b0;
        chk("oor_sat", o_dcnt, 8'd255);

        rand_phase(400);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_stream_n.md
# demux_stream_n

Registered 1-to-N stream demultiplexer: generalises the two-output gated demux to WIDTH-bit data, CHANNELS outputs and a valid/ready handshake on every side. Each output channel owns a one-entry holding register, so a stalled consumer blocks only its own channel. Two routing modes: addressed (per-beat select) and round-robin (internal pointer). It sits between the game-move source and per-cell/per-player consumers in the board datapath.

## Interface
- WIDTH, 8, data bits per beat (1..32)
- CHANNELS, 4, number of output channels (2..16); SEL_W = clog2(CHANNELS) is derived, not overridable

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = addressed (route by in_sel), 1 = round-robin (route by rr_ptr)
- in_valid  input  1  source beat present
- in_ready  output  1  block accepts beat this cycle
- in_data  input  WIDTH  beat payload
- in_sel  input  SEL_W  target channel in addressed mode; ignored in round-robin
- out_valid  output  CHANNELS  bit k: channel k register full
- out_ready  input  CHANNELS  bit k: consumer k takes beat this cycle
- out_data  output  CHANNELS*WIDTH  channel k payload in bits [k*WIDTH +: WIDTH]
- rr_ptr  output  SEL_W  next round-robin target
- drop_err  output  1  one-cycle pulse: beat discarded for out-of-range select
- drop_cnt  output  8  saturating count of discarded beats

## Operation
- Per-channel state: EMPTY or FULL (out_valid[k]). EMPTY->FULL on accept to k; FULL->EMPTY on out_valid[k]&out_ready[k] without new accept to k; FULL->FULL on simultaneous drain and accept to k (new data replaces old).
- Target t = in_sel (mode 0) or rr_ptr (mode 1).
- in_ready = 1 if t >= CHANNELS (mode 0 only), else ~out_valid[t] | out_ready[t]. in_ready never depends on in_valid.
- Accept = in_valid & in_ready. On accept to valid t: out_data[t] <= in_data, out_valid[t] <= 1.
- Out-of-range in_sel (possible only when CHANNELS not a power of two): beat accepted and discarded, drop_err = 1 next cycle, drop_cnt += 1, saturating at 255. No channel changes.
- rr_ptr advances only on accept in mode 1; CHANNELS-1 wraps to 0. Holds in mode 0.
- Mode switch takes effect the same cycle mode changes; rr_ptr value retained across switches.
- Channels other than t are never disturbed by an accept.
- out_data[k] stable while out_valid[k] & ~out_ready[k]. Consumer may assert out_ready while out_valid low; no effect.
- Source rule: once in_valid is high, in_data/in_sel/mode hold until accept.

## Timing
- Reset (rst_n low, async): out_valid = 0, out_data = 0, rr_ptr = 0, drop_err = 0, drop_cnt = 0; in_ready reflects empty registers (1). Beats in flight are lost. Release is synchronised by the integrator; first accept possible on first edge after release.
- Latency: beat accepted at edge n appears with out_valid[t] = 1 after edge n, visible cycle n+1.
- Throughput: one beat per cycle into the block; sustained one beat per cycle into a single channel when its consumer holds out_ready = 1.
- drop_err high exactly one cycle per discarded beat; back-to-back drops keep it high.
- in_ready is combinational from registered state, mode, in_sel and out_ready.

## Test plan
- Reset: hold rst_n low mid-traffic with channel 2 FULL -> all out_valid = 0, out_data = 0, rr_ptr = 0, drop_cnt = 0 immediately, in_ready = 1.
- Addressed routing, CHANNELS=4: send 0xA1 sel 0, 0xB2 sel 3 -> out_valid = 4'b1001 one cycle after each accept, out_data ch0 = 0xA1, ch3 = 0xB2; ch1/ch2 untouched.
- Backpressure: ch1 FULL with out_ready[1] = 0, send sel 1 -> in_ready = 0, ch1 data unchanged; raise out_ready[1] -> accept same cycle, ch1 holds new beat next cycle with out_valid[1] still 1.
- Round-robin: mode 1, all out_ready = 1, send 6 beats 0x10..0x15 -> channels 0,1,2,3,0,1 receive them in order, rr_ptr ends at 2; switch to mode 0 -> rr_ptr stays 2.
- Out-of-range, CHANNELS=3: send sel 3 -> in_ready = 1, no out_valid change, drop_err one-cycle pulse, drop_cnt = 1; 300 such beats -> drop_cnt = 255.
- Simultaneous drain/fill on ch0 every cycle for 8 beats -> out_valid[0] continuously 1, every beat delivered once in order, no stall.
